// File: rtl/microcode_sequencer_if.sv
// -----------------------------------------------------------------------------
// microcode_sequencer_if
//   Bundles the instruction/flag inputs, the microcode-store write port and the
//   control outputs of microcode_sequencer.
//
//   master : the instruction-register / flag side (drives opcode, flag, stall,
//            uc_we, uc_addr, uc_data; observes the control outputs).
//   slave  : the sequencer itself.
//
//   Signals
//     opcode      [OPCODE_W]          instruction opcode, sampled in DECODE
//     flag                            ALU condition flag, sampled in EXEC
//     stall                           hold current state/step
//     uc_we                           microcode write enable
//     uc_addr     [OPCODE_W+STEP_W]   write address {opcode, step}
//     uc_data     [SIG_W+2]           {cond, last, signals}
//     signals     [SIG_W]             datapath control-signal bus
//     step        [STEP_W]            current micro-step
//     instr_done                      pulse on the final EXEC cycle
//     halted                          high in HALT
//     instr_count [16]                retired-instruction count (0 unless the
//                                     performance counter is built in)
//
//   Parameters must match those given to microcode_sequencer.
// -----------------------------------------------------------------------------
interface microcode_sequencer_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned SIG_W    = 17,
  parameter int unsigned STEPS    = 4
);
  localparam int unsigned STEP_W = $clog2(STEPS);

  logic [OPCODE_W-1:0]        opcode;
  logic                       flag;
  logic                       stall;
  logic                       uc_we;
  logic [OPCODE_W+STEP_W-1:0] uc_addr;
  logic [SIG_W+1:0]           uc_data;

  logic [SIG_W-1:0]           signals;
  logic [STEP_W-1:0]          step;
  logic                       instr_done;
  logic                       halted;
  logic [15:0]                instr_count;

  modport master (
    output opcode, flag, stall, uc_we, uc_addr, uc_data,
    input  signals, step, instr_done, halted, instr_count
  );

  modport slave (
    input  opcode, flag, stall, uc_we, uc_addr, uc_data,
    output signals, step, instr_done, halted, instr_count
  );
endinterface

// File: rtl/microcode_sequencer.sv
// -----------------------------------------------------------------------------
// microcode_sequencer
//   Multi-cycle control unit. Runs FETCH -> DECODE -> EXEC and, in EXEC, steps
//   through a writable microcode store addressed by {opcode_q, step}. One
//   microword is driven onto the control bus per EXEC cycle. A microword may
//   end the instruction early (last bit), or conditionally on the ALU flag
//   (cond bit set and flag low). HALT_OP enters an absorbing HALT state.
//
//   Ports
//     clk   : system clock, rising edge
//     rst   : asynchronous, active-high reset
//     bus   : microcode_sequencer_if.slave (see interface file for signals)
//
//   Microword layout: [SIG_W+1]=cond, [SIG_W]=last, [SIG_W-1:0]=signals.
//
//   Optional build macro MICROCODE_SEQUENCER_PERF_EN adds a saturating 16-bit
//   count of completed instructions on bus.instr_count; without it that output
//   is tied to zero.
// -----------------------------------------------------------------------------
module microcode_sequencer #(
  parameter int unsigned         OPCODE_W  = 4,
  parameter int unsigned         SIG_W     = 17,
  parameter int unsigned         STEPS     = 4,
  parameter logic [SIG_W-1:0]    FETCH_SIG = 17'h00001,
  parameter logic [OPCODE_W-1:0] HALT_OP   = 4'hF
) (
  input  logic                       clk,
  input  logic                       rst,
  microcode_sequencer_if.slave       bus
);

  localparam int unsigned STEP_W  = $clog2(STEPS);
  localparam int unsigned ADDR_W  = OPCODE_W + STEP_W;
  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned WORD_W  = SIG_W + 2;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------------
  state_t              state_q,  state_d;
  logic [STEP_W-1:0]   step_q,   step_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;

  // Microcode store: not reset, written from the bus in any state.
  logic [WORD_W-1:0]   mem_q [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]   uword;
  logic                uw_cond;
  logic                uw_last;
  logic [SIG_W-1:0]    uw_sig;
  logic                exec_end;

  logic [SIG_W-1:0]    sig_c;
  logic                done_c;
  logic                halted_c;

  // ---------------------------------------------------------------------------
  // Microcode store
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (bus.uc_we) begin
      mem_q[bus.uc_addr] <= bus.uc_data;
    end
  end

  // Read is combinational, so a write to the word being executed shows up on
  // the cycle after the write edge.
  assign uword   = mem_q[{opcode_q, step_q}];
  assign uw_cond = uword[SIG_W+1];
  assign uw_last = uword[SIG_W];
  assign uw_sig  = uword[SIG_W-1:0];

  // Last step forces termination so step never wraps; a conditional word
  // with the flag clear terminates early.
  assign exec_end = uw_last || (step_q == LAST_STEP) || (uw_cond && !bus.flag);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FETCH;
      step_q   <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      opcode_q <= opcode_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    opcode_d = opcode_q;
    sig_c    = '0;
    done_c   = 1'b0;
    halted_c = 1'b0;

    case (state_q)
      ST_FETCH: begin
        sig_c = FETCH_SIG;
        if (!bus.stall) begin
          state_d = ST_DECODE;
        end
      end

      // DECODE is always a single cycle; stall is deliberately ignored here.
      ST_DECODE: begin
        opcode_d = bus.opcode;
        if (bus.opcode == HALT_OP) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_EXEC;
          step_d  = '0;
        end
      end

      ST_EXEC: begin
        sig_c = uw_sig;
        if (!bus.stall) begin
          if (exec_end) begin
            done_c  = 1'b1;
            state_d = ST_FETCH;
            step_d  = '0;
          end else begin
            step_d  = step_q + 1'b1;
          end
        end
      end

      ST_HALT: begin
        halted_c = 1'b1;
      end

      default: begin
        state_d = ST_FETCH;
        step_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // While rst is held the state register already reads FETCH, which would
  // otherwise put FETCH_SIG on the bus; outputs are forced quiet instead.
  assign bus.signals    = rst ? '0   : sig_c;
  assign bus.instr_done = rst ? 1'b0 : done_c;
  assign bus.halted     = rst ? 1'b0 : halted_c;
  assign bus.step       = step_q;

`ifdef MICROCODE_SEQUENCER_PERF_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (done_c && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bus.instr_count = count_q;
`else
  assign bus.instr_count = '0;
`endif

endmodule

// File: tb/tb_microcode_sequencer.sv
module tb_microcode_sequencer;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned SIG_W    = 17;
  localparam int unsigned STEPS    = 4;

  logic clk    = 1'b0;
  logic clk_en = 1'b1;
  logic rst    = 1'b1;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [16:0] sig;
    logic        done;
    logic        halt;
    logic [1:0]  stp;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] exp_cnt = '0;

  microcode_sequencer_if #(
    .OPCODE_W (OPCODE_W),
    .SIG_W    (SIG_W),
    .STEPS    (STEPS)
  ) bus ();

  microcode_sequencer #(
    .OPCODE_W  (OPCODE_W),
    .SIG_W     (SIG_W),
    .STEPS     (STEPS),
    .FETCH_SIG (17'h00001),
    .HALT_OP   (4'hF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Gateable clock so reset can be applied with the clock stopped.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard push: the model's expected outputs for the cycle about to be sampled.
  task automatic expect_out(input logic [16:0] s, input logic d, input logic h,
                            input logic [1:0] st);
    exp_t e;
    e.sig  = s;
    e.done = d;
    e.halt = h;
    e.stp  = st;
`ifdef MICROCODE_SEQUENCER_PERF_EN
    e.cnt  = exp_cnt;
    if (d && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
    e.cnt  = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic sample_now();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("signals",     32'(bus.signals),     32'(e.sig));
      chk("instr_done",  32'(bus.instr_done),  32'(e.done));
      chk("halted",      32'(bus.halted),      32'(e.halt));
      chk("step",        32'(bus.step),        32'(e.stp));
      chk("instr_count", 32'(bus.instr_count), 32'(e.cnt));
    end
  endtask

  // One clock cycle: expectation pushed, outputs compared mid-cycle on the
  // falling edge, then return just after the next rising edge.
  task automatic cyc(input logic [16:0] s, input logic d, input logic h, input logic [1:0] st);
    expect_out(s, d, h, st);
    @(negedge clk);
    sample_now();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] op, input logic [1:0] st, input logic cond,
                    input logic last, input logic [16:0] sig);
    bus.uc_we   = 1'b1;
    bus.uc_addr = {op, st};
    bus.uc_data = {cond, last, sig};
    @(posedge clk);
    #1;
    bus.uc_we   = 1'b0;
  endtask

  initial begin
    bus.opcode  = '0;
    bus.flag    = 1'b0;
    bus.stall   = 1'b0;
    bus.uc_we   = 1'b0;
    bus.uc_addr = '0;
    bus.uc_data = '0;

    // Reset outputs.
    #1;
    expect_out(17'h0, 1'b0, 1'b0, 2'd0);
    sample_now();

    // Program the store while reset is held.
    wr(4'h8, 2'd0, 1'b0, 1'b0, 17'h00010);
    wr(4'h8, 2'd1, 1'b0, 1'b1, 17'h00200);
    wr(4'h3, 2'd0, 1'b1, 1'b0, 17'h00004);
    wr(4'h3, 2'd1, 1'b0, 1'b1, 17'h00008);
    wr(4'h5, 2'd0, 1'b0, 1'b0, 17'h00100);
    wr(4'h5, 2'd1, 1'b0, 1'b0, 17'h00200);
    wr(4'h5, 2'd2, 1'b0, 1'b0, 17'h00400);
    wr(4'h5, 2'd3, 1'b0, 1'b0, 17'h00800);
    rst = 1'b0;

    // Basic two-step instruction.
    bus.opcode = 4'h8;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    cyc(17'h00010, 1'b0, 1'b0, 2'd0);
    cyc(17'h00200, 1'b1, 1'b0, 2'd1);

    // Conditional exit taken (flag low), back-to-back with previous.
    bus.opcode = 4'h3;
    bus.flag   = 1'b0;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    cyc(17'h00004, 1'b1, 1'b0, 2'd0);

    // Conditional word with flag high continues.
    bus.flag = 1'b1;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    cyc(17'h00004, 1'b0, 1'b0, 2'd0);
    cyc(17'h00008, 1'b1, 1'b0, 2'd1);

    // Stall at step 1 for 3 cycles, then run to the step limit.
    bus.opcode = 4'h5;
    bus.flag   = 1'b0;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    cyc(17'h00100, 1'b0, 1'b0, 2'd0);
    bus.stall = 1'b1;
    cyc(17'h00200, 1'b0, 1'b0, 2'd1);
    cyc(17'h00200, 1'b0, 1'b0, 2'd1);
    cyc(17'h00200, 1'b0, 1'b0, 2'd1);
    bus.stall = 1'b0;
    cyc(17'h00200, 1'b0, 1'b0, 2'd1);
    cyc(17'h00400, 1'b0, 1'b0, 2'd2);
    cyc(17'h00800, 1'b1, 1'b0, 2'd3);

    // Stall holds FETCH.
    bus.stall = 1'b1;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    bus.stall = 1'b0;

    // Asynchronous reset mid-EXEC with the clock stopped.
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    cyc(17'h00100, 1'b0, 1'b0, 2'd0);
    cyc(17'h00200, 1'b0, 1'b0, 2'd1);
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    expect_out(17'h00400, 1'b0, 1'b0, 2'd2);
    sample_now();
    rst     = 1'b1;
    exp_cnt = '0;
    #1;
    expect_out(17'h0, 1'b0, 1'b0, 2'd0);
    sample_now();
    #10;
    expect_out(17'h0, 1'b0, 1'b0, 2'd0);
    sample_now();
    clk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // HALT is absorbing.
    bus.opcode = 4'hF;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);
    cyc(17'h00000, 1'b0, 1'b0, 2'd0);
    repeat (20) cyc(17'h00000, 1'b0, 1'b1, 2'd0);
    rst     = 1'b1;
    exp_cnt = '0;
    #1;
    expect_out(17'h0, 1'b0, 1'b0, 2'd0);
    sample_now();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Five back-to-back instructions of opcode 8.
    bus.opcode = 4'h8;
    repeat (5) begin
      cyc(17'h00001, 1'b0, 1'b0, 2'd0);
      cyc(17'h00000, 1'b0, 1'b0, 2'd0);
      cyc(17'h00010, 1'b0, 1'b0, 2'd0);
      cyc(17'h00200, 1'b1, 1'b0, 2'd1);
    end
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);

    // Reset clears the counter.
    rst     = 1'b1;
    exp_cnt = '0;
    #1;
    expect_out(17'h0, 1'b0, 1'b0, 2'd0);
    sample_now();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(17'h00001, 1'b0, 1'b0, 2'd0);

    if (sb.size() != 0) chk("scoreboard_leftover", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
